// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and anode decode for the four-digit scan multiplexer
//   NDIG       - number of multiplexed digits
//   SSEG_BLANK - all segments (and dp) off, active-low
//   AN_OFF     - all anodes off, active-low
package sseg_pkg;
  localparam int NDIG = 4;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [NDIG-1:0] AN_OFF = 4'b1111;
  function automatic logic [NDIG-1:0] an_onehot_low(input logic [1:0] sel);
    return ~(NDIG'(1) << sel);
  endfunction
endpackage

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: time-multiplexed 4-digit seven-segment driver with dimming, blanking and blink
//   clk            in   system clock, all state on rising edge
//   reset_n        in   asynchronous active-low reset
//   in0..in3       in   active-low segment patterns (bit 7 = dp), in0 = rightmost digit
//   blank          in   per-digit force-off mask
//   blink_en       in   per-digit blink enable
//   duty           in   brightness 0 (1/16 on) .. 15 (always on)
//   an             out  active-low anodes, at most one low
//   sseg           out  active-low segments, bit 7 = dp
//   frame_tick     out  one-cycle pulse after each refresh-counter wrap
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int REFRESH_W = 18,
  parameter int BLINK_W   = 26
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      in0,
  input  logic [7:0]      in1,
  input  logic [7:0]      in2,
  input  logic [7:0]      in3,
  input  logic [NDIG-1:0] blank,
  input  logic [NDIG-1:0] blink_en,
  input  logic [3:0]      duty,
  output logic [NDIG-1:0] an,
  output logic [7:0]      sseg,
  output logic            frame_tick
);
  localparam logic [REFRESH_W-1:0] R_ONE = 1;
  localparam logic [BLINK_W-1:0]   B_ONE = 1;
  logic [REFRESH_W-1:0]     rcnt_q, rcnt_d;
  logic [BLINK_W-1:0]       bcnt_q, bcnt_d;
  logic                     phase_q, phase_d;
  logic [NDIG-1:0][7:0]     pat_q, pat_d;
  logic [NDIG-1:0]          blank_q, blank_d;
  logic [NDIG-1:0]          blink_q, blink_d;
  logic [3:0]               duty_q, duty_d;
  logic [NDIG-1:0]          an_q, an_d;
  logic [7:0]               sseg_q, sseg_d;
  logic                     tick_q, tick_d;
  logic                     wrap, lit;
  logic [1:0]               sel;
  logic [3:0]               dim;
  // Shadows reload only at the frame boundary so a frame is never drawn from
  // a mix of old and new inputs; anode and pattern are registered together so
  // they always switch on the same edge.
  always_comb begin
    wrap    = &rcnt_q;
    rcnt_d  = rcnt_q + R_ONE;
    bcnt_d  = bcnt_q + B_ONE;
    phase_d = phase_q ^ (&bcnt_q);
    pat_d   = wrap ? {in3, in2, in1, in0} : pat_q;
    blank_d = wrap ? blank : blank_q;
    blink_d = wrap ? blink_en : blink_q;
    duty_d  = wrap ? duty : duty_q;
    tick_d  = wrap;
    sel     = rcnt_q[REFRESH_W-1 -: 2];
    dim     = rcnt_q[REFRESH_W-3 -: 4];
    lit     = (dim <= duty_q) && !blank_q[sel] && !(blink_q[sel] && phase_q);
    an_d    = lit ? an_onehot_low(sel) : AN_OFF;
    sseg_d  = lit ? pat_q[sel] : SSEG_BLANK;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      pat_q   <= {NDIG{SSEG_BLANK}};
      blank_q <= '1;
      blink_q <= '0;
      duty_q  <= '0;
      an_q    <= AN_OFF;
      sseg_q  <= SSEG_BLANK;
      tick_q  <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      duty_q  <= duty_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      tick_q  <= tick_d;
    end
  end
  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: directed frame-by-frame checks of scan, dimming, blank/blink, tearing and reset
module tb_sseg_scan_mux;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] blank, blink_en, duty;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;
  int n_chk = 0;
  int n_fail = 0;
  int inv_bad = 0;
  int k = 0;
  int lit [4];
  int pat_ok [4];
  logic [7:0] exp_pat [4];
  int ft_cnt;
  logic ft_last;

  sseg_scan_mux #(.REFRESH_W(8), .BLINK_W(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .blank(blank), .blink_en(blink_en), .duty(duty),
    .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!(an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}) || (an == 4'hF && sseg != 8'hFF))
      inv_bad++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic run_frame();
    for (int i = 0; i < 4; i++) begin
      lit[i] = 0;
      pat_ok[i] = 0;
    end
    ft_cnt = 0;
    repeat (256) begin
      step();
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b0001 << i)) begin
          lit[i]++;
          if (sseg == exp_pat[i]) pat_ok[i]++;
        end
      if (frame_tick) ft_cnt++;
    end
    ft_last = frame_tick;
  endtask

  task automatic frame(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    run_frame();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s lit d%0d", tag, i), lit[i], e[i]);
      check($sformatf("%s pattern d%0d", tag, i), pat_ok[i], e[i]);
    end
    check($sformatf("%s frame_tick count", tag), ft_cnt, 1);
    check($sformatf("%s frame_tick at wrap", tag), ft_last, 1);
  endtask

  initial begin
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
    blank = 4'b0000; blink_en = 4'b0000; duty = 4'd15;
    exp_pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    repeat (2) @(negedge clk);
    check("reset an", an, 4'hF);
    check("reset sseg", sseg, 8'hFF);
    check("reset frame_tick", frame_tick, 1'b0);
    reset_n = 1'b1;
    k = 0;
    frame("dark after reset", 0, 0, 0, 0);
    frame("scan full", 64, 64, 64, 64);
    duty = 4'd3;
    frame("duty change held", 64, 64, 64, 64);
    frame("duty 3", 16, 16, 16, 16);
    duty = 4'd0;
    frame("duty 0 held", 16, 16, 16, 16);
    frame("duty 0", 4, 4, 4, 4);
    duty = 4'd15; blank = 4'b0100; blink_en = 4'b0001;
    frame("blank change held", 4, 4, 4, 4);
    frame("blink phase 1", 0, 64, 0, 64);
    frame("blink phase 0", 64, 64, 0, 64);
    blank = 4'b0000; blink_en = 4'b0000; in1 = 8'h80;
    frame("tearing old value", 64, 64, 0, 64);
    exp_pat[1] = 8'h80;
    frame("tearing new value", 64, 64, 64, 64);
    repeat (130) step();
    check("digit 2 before reset an", an, 4'b1011);
    check("digit 2 before reset sseg", sseg, 8'hA4);
    #2 reset_n = 1'b0;
    #1;
    check("async reset an", an, 4'hF);
    check("async reset sseg", sseg, 8'hFF);
    check("async reset frame_tick", frame_tick, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    frame("dark after mid reset", 0, 0, 0, 0);
    frame("scan after mid reset", 64, 64, 64, 64);
    check("invariant violations", inv_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 Parameter REFRESH_W, default 18: refresh counter width; digit slot = 2^(REFRESH_W-2) clk cycles; minimum 8.
REQ-002 Parameter BLINK_W, default 26: blink counter width; blink phase toggles every 2^BLINK_W clk cycles.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in0, in1, in2, in3  input  8 each  encoded segment patterns, active-low, bit 7 = dp; in0 = rightmost digit.
REQ-006 blank  input  4  per-digit force-off mask; bit i blanks digit i.
REQ-007 blink_en  input  4  per-digit blink enable.
REQ-008 duty  input  4  brightness, 0 (dimmest) .. 15 (full on).
REQ-009 an  output  4  digit anodes, active-low, at most one bit low at a time.
REQ-010 sseg  output  8  segment drive, active-low, bit 7 = dp.
REQ-011 frame_tick  output  1  one-cycle pulse at each refresh-counter wrap.

Function
REQ-012 Free-running refresh counter rcnt[REFRESH_W-1:0] SHALL increment every clk, wrapping from all-ones to 0.
REQ-013 Digit select sel = rcnt[REFRESH_W-1:REFRESH_W-2]; dim slice d = rcnt[REFRESH_W-3:REFRESH_W-6].
REQ-014 in0..in3, blank, blink_en and duty SHALL be captured into shadow registers only on the cycle rcnt wraps to 0; the display SHALL use shadow values only (no mid-frame tearing).
REQ-015 Digit sel SHALL be lit when d <= duty_sh, blank_sh[sel] = 0, and NOT (blink_en_sh[sel] = 1 AND blink phase = 1).
REQ-016 Lit: an = one-hot-low at sel, sseg = shadow pattern of sel; unlit: an = 4'b1111, sseg = 8'hFF.
REQ-017 an and sseg SHALL be registered; they reflect the rcnt value of the previous cycle (latency 1 clk).
REQ-018 an and sseg SHALL change on the same edge; no cycle with a new anode and the old pattern.
REQ-019 Blink counter SHALL run freely; blink phase toggles when it wraps and starts at 0.
REQ-020 frame_tick SHALL be high for exactly the one cycle after rcnt wraps (same edge as the shadow capture).
REQ-021 duty = 15 SHALL give 100 % on-time; duty = 0 SHALL give 1/16 on-time.
REQ-022 Inputs changing between frame boundaries SHALL have no effect until the next wrap.

Reset
REQ-023 On reset_n low: rcnt = 0, blink counter = 0, blink phase = 0, shadows = in* 8'hFF, blank 4'hF, blink_en 0, duty 0; an = 4'b1111, sseg = 8'hFF, frame_tick = 0.
REQ-024 Reset assertion mid-frame SHALL blank the outputs asynchronously, with no glitch to a lit state.
REQ-025 After reset release, the display stays dark until the first frame boundary loads the shadows.

Structure
REQ-026 Shared package sseg_pkg SHALL hold SSEG_BLANK = 8'hFF, AN_OFF = 4'b1111 and the digit-count constant NDIG = 4.
REQ-027 Single module; no sub-module. The refresh and blink counters live in this module.

Verification (benches use REFRESH_W = 8, BLINK_W = 10)
REQ-028 Scan: in0..3 = 8'hC0, 8'hF9, 8'hA4, 8'hB0, duty 15, blank 0 -> an cycles 1110, 1101, 1011, 0111 for 64 clk each; sseg matches per digit; frame_tick every 256 clk.
REQ-029 Dimming: duty = 3 -> each digit is lit for 16 of 64 slot cycles (d = 0..3 of each 16-cycle block); duty = 0 -> lit for 4 of 64.
REQ-030 Blank/blink: blank = 4'b0100, blink_en = 4'b0001 -> digit 2 never lit; digit 0 dark during every other 1024-cycle phase.
REQ-031 Tearing: change in1 from 8'hF9 to 8'h80 mid-frame -> old value shown until frame_tick, new value from the next frame.
REQ-032 Reset: assert reset_n low during digit 2 -> an = 1111 and sseg = FF immediately; after release, dark for 256 cycles, then normal scan.
REQ-033 Invariant checked every cycle: an is one-hot-low or 1111; an = 1111 implies sseg = 8'hFF.
